// File: rtl/sh_pkg.sv
// Shared types for the multi-cycle shift register: the shift-mode encoding and the FSM states.
package sh_pkg;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } sh_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } sh_state_e;

endpackage

// File: rtl/sh_step.sv
// One-bit shift step: next register value and the bit shifted out, for a given mode.
// Rotate datapath exists only when SH_ROTATE_EN is defined; otherwise ROR decodes as LSR.
module sh_step
  import sh_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] q_in,
  input  sh_mode_e     mode,
  output logic [W-1:0] q_out,
  output logic         carry_out
);

  always_comb begin
    q_out     = {1'b0, q_in[W-1:1]};
    carry_out = q_in[0];
    case (mode)
      MODE_LSL: begin
        q_out     = {q_in[W-2:0], 1'b0};
        carry_out = q_in[W-1];
      end
      MODE_ASR: begin
        q_out     = {q_in[W-1], q_in[W-1:1]};
        carry_out = q_in[0];
      end
`ifdef SH_ROTATE_EN
      MODE_ROR: begin
        q_out     = {q_in[0], q_in[W-1:1]};
        carry_out = q_in[0];
      end
`endif
      default: begin
        q_out     = {1'b0, q_in[W-1:1]};
        carry_out = q_in[0];
      end
    endcase
  end

endmodule

// File: rtl/sh_rgst_mc.sv
// Multi-cycle shift register: loads in parallel, then shifts one bit per clock (IDLE/SHIFT/DONE).
// Optional macro SH_ROTATE_EN enables ROR for mode 11; without it mode 11 acts as LSR.
module sh_rgst_mc
  import sh_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  d,
  input  logic          ld,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] amt,
  output logic [W-1:0]  q,
  output logic          busy,
  output logic          done,
  output logic          carry
);

  localparam int CW = $clog2(W) + 1;

  sh_state_e     state_q, state_d;
  sh_mode_e      mode_q, mode_d;
  logic [W-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  sh_mode_e      mode_in;
  sh_mode_e      mode_eff;
  logic [CW-1:0] n_eff;
  logic [W-1:0]  step_q;
  logic          step_c;

  assign mode_in = sh_mode_e'(mode);

  // Shifting amounts saturate at W; a rotate only needs amt mod W steps.
  always_comb begin
    n_eff    = (32'(amt) >= 32'(W)) ? CW'(W) : CW'(amt);
    mode_eff = mode_in;
`ifdef SH_ROTATE_EN
    if (mode_in == MODE_ROR) n_eff = CW'(amt) & CW'(W - 1);
`else
    if (mode_in == MODE_ROR) mode_eff = MODE_LSR;
`endif
  end

  sh_step #(.W(W)) u_step (
    .q_in      (q_q),
    .mode      (mode_q),
    .q_out     (step_q),
    .carry_out (step_c)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld) begin
          q_d = d;
        end else if (start) begin
          mode_d  = mode_eff;
          carry_d = 1'b0;
          cnt_d   = n_eff;
          if (n_eff != '0) begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        q_d     = step_q;
        carry_d = step_c;
        cnt_d   = cnt_q - 1'b1;
        // cnt_q == 1 means this edge performs the last shift.
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LSL;
      q_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q     = q_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_sh_rgst_mc.sv
// Self-checking bench for sh_rgst_mc (W=8, AW=4): directed scenarios plus randomized operations
// checked against an arithmetic model of the whole multi-bit shift.
module tb_sh_rgst_mc;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic [W-1:0]  d;
  logic          ld;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] amt;
  logic [W-1:0]  q;
  logic          busy;
  logic          done;
  logic          carry;

  int checks   = 0;
  int failures = 0;

  sh_rgst_mc #(.W(W), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .ld    (ld),
    .start (start),
    .mode  (mode),
    .amt   (amt),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .carry (carry)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: result of applying the whole operation at once.
  function automatic void model(input logic [W-1:0] q0, input logic [1:0] m, input int a,
                                output int n, output logic [W-1:0] qf, output logic cf);
    logic [1:0] em;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    em = m;
`ifdef SH_ROTATE_EN
    n = (m == 2'b11) ? (a % W) : ((a > W) ? W : a);
`else
    if (m == 2'b11) em = 2'b01;
    n = (a > W) ? W : a;
`endif
    qf = q0;
    cf = 1'b0;
    if (n > 0) begin
      case (em)
        2'b00: begin
          qf = q0 << n;
          cf = q0[W-n];
        end
        2'b01: begin
          qf = q0 >> n;
          cf = q0[n-1];
        end
        2'b10: begin
          qf = W'($signed(q0) >>> n);
          cf = q0[n-1];
        end
        default: begin
          lo = q0 >> n;
          hi = q0 << (W - n);
          qf = lo | hi;
          cf = q0[n-1];
        end
      endcase
    end
  endfunction

  // Driver tasks
  task automatic do_ld(input logic [W-1:0] val);
    @(negedge clk);
    d  = val;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Pulses start, then watches busy/done each cycle; poke scribbles ld/start/mode/amt while busy or done.
  task automatic run_op(input logic [1:0] m, input int a, input bit poke,
                        output int busy_n, output int done_n, output int done_at);
    @(negedge clk);
    mode  = m;
    amt   = AW'(a);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    for (int c = 0; c < 40; c++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && c > done_at) break;
      if (poke && (busy || done)) begin
        ld    = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        d     = W'($urandom);
        mode  = 2'($urandom);
        amt   = AW'($urandom);
      end else begin
        ld    = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
    end
    ld    = 1'b0;
    start = 1'b0;
  endtask

  // Loads q0, runs one operation and compares everything observable with the model.
  task automatic op_and_check(input string name, input logic [W-1:0] q0, input logic [1:0] m,
                              input int a, input bit poke);
    int n, busy_n, done_n, done_at;
    logic [W-1:0] exp_q;
    logic exp_c;
    model(q0, m, a, n, exp_q, exp_c);
    do_ld(q0);
    checks++;
    if (q !== q0) begin
      failures++;
      $display("FAIL %s_load q=%h expected %h", name, q, q0);
    end
    run_op(m, a, poke, busy_n, done_n, done_at);
    checks++;
    if (done_at != n) begin
      failures++;
      $display("FAIL %s_done_latency done_at=%0d expected %0d", name, done_at, n);
    end
    checks++;
    if (busy_n != n) begin
      failures++;
      $display("FAIL %s_busy_cycles busy=%0d expected %0d", name, busy_n, n);
    end
    checks++;
    if (done_n != 1) begin
      failures++;
      $display("FAIL %s_done_pulses count=%0d expected 1", name, done_n);
    end
    checks++;
    if (q !== exp_q || carry !== exp_c) begin
      failures++;
      $display("FAIL %s_result q=%h carry=%b expected q=%h carry=%b", name, q, carry, exp_q, exp_c);
    end
  endtask

  // Tests
  task automatic test_reset();
    do_ld(8'h5A);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || carry !== 1'b0) begin
      failures++;
      $display("FAIL reset_async q=%h busy=%b done=%b carry=%b expected 00 0 0 0", q, busy, done, carry);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lsl();
    op_and_check("lsl_b4_3", 8'hB4, 2'b00, 3, 1'b0);
    checks++;
    if (q !== 8'hA0 || carry !== 1'b1) begin
      failures++;
      $display("FAIL lsl_fixed q=%h carry=%b expected a0 1", q, carry);
    end
  endtask

  task automatic test_asr();
    logic [W-1:0] held;
    op_and_check("asr_90_2", 8'h90, 2'b10, 2, 1'b0);
    checks++;
    if (q !== 8'hE4 || carry !== 1'b0) begin
      failures++;
      $display("FAIL asr_fixed q=%h carry=%b expected e4 0", q, carry);
    end
    held = 8'hE4;
    op_and_check("asr_zero", held, 2'b10, 0, 1'b0);
  endtask

  task automatic test_mode3();
    op_and_check("mode3_81_9", 8'h81, 2'b11, 9, 1'b0);
`ifdef SH_ROTATE_EN
    checks++;
    if (q !== 8'hC0 || carry !== 1'b1) begin
      failures++;
      $display("FAIL ror_fixed q=%h carry=%b expected c0 1", q, carry);
    end
`else
    checks++;
    if (q !== 8'h00 || carry !== 1'b1) begin
      failures++;
      $display("FAIL mode3_as_lsr q=%h carry=%b expected 00 1", q, carry);
    end
`endif
  endtask

  task automatic test_lsr_clamp();
    op_and_check("lsr_ff_12_poke", 8'hFF, 2'b01, 12, 1'b1);
    checks++;
    if (q !== 8'h00) begin
      failures++;
      $display("FAIL lsr_clamp q=%h expected 00", q);
    end
  endtask

  task automatic test_idle_hold();
    logic [W-1:0] snap_q;
    logic snap_c;
    snap_q = q;
    snap_c = carry;
    repeat (4) @(negedge clk);
    checks++;
    if (q !== snap_q || carry !== snap_c || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold q=%h carry=%b expected %h %b", q, carry, snap_q, snap_c);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    do_ld(8'h3C);
    @(negedge clk);
    mode  = 2'b00;
    amt   = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || carry !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid q=%h busy=%b done=%b carry=%b expected 00 0 0 0", q, busy, done, carry);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 8; c++) begin
      if (done || busy) seen_done++;
      @(negedge clk);
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL reset_mid_no_done activity_cycles=%0d expected 0", seen_done);
    end
    op_and_check("after_reset", 8'hC3, 2'b00, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      op_and_check($sformatf("rand%0d", i), W'($urandom), 2'($urandom),
                   $urandom_range(0, (1 << AW) - 1), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst   = 1'b1;
    d     = '0;
    ld    = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    amt   = '0;
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || carry !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial q=%h busy=%b done=%b carry=%b expected 00 0 0 0", q, busy, done, carry);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_lsl();
    test_asr();
    test_mode3();
    test_lsr_clamp();
    test_idle_hold();
    test_reset_mid();
    test_random();
    test_idle_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sh_rgst_mc.md
SH_RGST_MC -- requirements
Module: sh_rgst_mc

Interface
REQ-001 SHALL have parameter W, default 8, data width (W >= 2, power of two).
REQ-002 SHALL have parameter AW, default 4, width of the shift-amount input.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port d  input  W  parallel load data.
REQ-006 SHALL have port ld  input  1  parallel load request.
REQ-007 SHALL have port start  input  1  shift operation request.
REQ-008 SHALL have port mode  input  2  shift mode: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-009 SHALL have port amt  input  AW  requested shift amount, unsigned.
REQ-010 SHALL have port q  output  W  register contents.
REQ-011 SHALL have port busy  output  1  high while shifting.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port carry  output  1  last bit shifted out.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; busy=1 only in SHIFT, done=1 only in DONE.
REQ-015 In IDLE, ld=1 SHALL load q<=d; start SHALL be ignored that cycle (ld wins).
REQ-016 In IDLE, start=1 with ld=0 SHALL latch mode, clear carry, load the counter with the effective amount n, and go to SHIFT (n>0) or DONE (n=0).
REQ-017 Effective amount: LSL/LSR/ASR n=min(amt,W); ROR n=amt mod W.
REQ-018 In SHIFT, each cycle SHALL shift q by exactly one bit per the latched mode, set carry to the bit shifted out, and decrement the counter; after the n-th shift go to DONE.
REQ-019 Bit step: LSL fills 0 at LSB, carry=old MSB; LSR fills 0 at MSB, carry=old LSB; ASR fills old MSB, carry=old LSB; ROR moves old LSB to MSB, carry=old LSB.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE; q and carry hold.
REQ-021 Latency: start sampled at edge k; shifts at edges k+1..k+n; done high during the cycle after edge k+n (n=0: after edge k).
REQ-022 ld, start, mode and amt SHALL be ignored in SHIFT and DONE.
REQ-023 q and carry SHALL hold their values in IDLE when neither ld nor start is asserted.

Reset
REQ-024 rst=1 SHALL immediately force q=0, carry=0, busy=0, done=0, counter=0, state IDLE, independent of clk.
REQ-025 Reset asserted mid-operation SHALL abort the operation; no done pulse is produced for it.

Configuration
REQ-026 Macro SH_ROTATE_EN defined: mode 11 SHALL perform ROR per REQ-017/REQ-019.
REQ-027 Macro SH_ROTATE_EN undefined: mode 11 SHALL behave exactly as LSR, including n=min(amt,W), and no rotate logic is synthesised.

Structure
REQ-028 Package sh_pkg SHALL hold the mode encoding type (LSL, LSR, ASR, ROR) and the FSM state type.
REQ-029 A combinational sub-module sh_step SHALL compute one-bit shift result and carry from q and mode; sh_rgst_mc instantiates it once.

Verification (W=8, AW=4)
REQ-030 Reset: assert rst between edges -> q=0, busy=0, done=0, carry=0 without waiting for a clock edge.
REQ-031 ld d=8'hB4, then start LSL amt=3 -> busy for 3 cycles, q=8'hA0, carry=1, done pulse once.
REQ-032 ld 8'h90, start ASR amt=2 -> q=8'hE4, carry=0; start ASR amt=0 -> done next cycle, q unchanged.
REQ-033 ld 8'h81, start mode 11 amt=9 -> with SH_ROTATE_EN: 1 shift, q=8'hC0, carry=1; without it: 8 shifts, q=8'h00, carry=1.
REQ-034 ld 8'hFF, start LSR amt=12 -> 8 shifts (clamped), q=8'h00; ld/start pulsed while busy -> no effect.
REQ-035 Start LSL amt=5, assert rst after 2 shifts -> q=0, IDLE, no done; a new ld+start afterwards completes normally.
